// File: rtl/pipe_reg_skid.sv
// Purpose : inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Latency : 1 cycle from accept to OutValid when empty; 1 beat/cycle sustained throughput.
// Backpressure: InReady comes from registered state only; it drops when both entries are held.
//
// Ports:
//   CLK, RST           clock and synchronous active-high reset
//   InValid/InReady    upstream handshake, InData carries the payload
//   Stall              hazard hold; blocks consumption of the head entry
//   Flush              synchronous clear of all held payloads
//   OutValid/OutReady  downstream handshake, OutData is the head or CLR_VAL when empty
//   Count              number of entries held (0..2)
//   BpCycles           saturating count of cycles with OutValid=1 and no consume
module pipe_reg_skid #(
  parameter int              SIZE    = 32,
  parameter logic [SIZE-1:0] CLR_VAL = {SIZE{1'b0}},
  parameter int              CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             InValid,
  output logic             InReady,
  input  logic [SIZE-1:0]  InData,
  input  logic             Stall,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [SIZE-1:0]  OutData,
  output logic [1:0]       Count,
  output logic [CNT_W-1:0] BpCycles
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] BP_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [SIZE-1:0]  main_q, main_d;
  logic [SIZE-1:0]  skid_q, skid_d;
  logic [CNT_W-1:0] bp_q, bp_d;

  logic accept;
  logic consume;

  // InReady depends only on RST and the state register, so the ready
  // path towards upstream never sees OutReady or Stall combinationally.
  assign InReady  = ~RST & (state_q != FULL);
  assign OutValid = (state_q != EMPTY);
  assign OutData  = main_q;
  assign Count    = state_q;
  assign BpCycles = bp_q;

  assign accept  = InValid & InReady;
  assign consume = OutValid & OutReady & ~Stall;

  // Next-state and payload steering.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (Flush) begin
      // Flush wins over Stall and drops any payload offered this cycle.
      state_d = EMPTY;
      main_d  = CLR_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = InData;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_d = InData;
          end else if (accept) begin
            // Head is stuck, park the new beat behind it.
            state_d = FULL;
            skid_d  = InData;
          end else if (consume) begin
            state_d = EMPTY;
            main_d  = CLR_VAL;
          end
        end
        FULL: begin
          // InReady is low here, so only the head can move.
          if (consume) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = CLR_VAL;
        end
      endcase
    end
  end

  // Back-pressure counter: every cycle the head is presented but not taken,
  // including Stall holds and flush cycles without a consume.
  always_comb begin
    bp_d = bp_q;
    if (OutValid && !consume && (bp_q != BP_MAX)) begin
      bp_d = bp_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= EMPTY;
      main_q  <= CLR_VAL;
      skid_q  <= CLR_VAL;
      bp_q    <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      bp_q    <= bp_d;
    end
  end

endmodule
